// File: rtl/hs_pkg.sv
// Shared handshake types for both ends of the req/ack level crossing.
// Receiver and sender FSM state encodings live here so debug tooling sees one definition.
package hs_pkg;

    typedef enum logic [1:0] {
        ST_RX_IDLE = 2'd0,
        ST_RX_WAIT = 2'd1,
        ST_RX_ACK  = 2'd2
    } rx_state_e;

    typedef enum logic [1:0] {
        ST_TX_IDLE     = 2'd0,
        ST_TX_REQ      = 2'd1,
        ST_TX_ACK_LOW  = 2'd2
    } tx_state_e;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int unsigned fill_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hs_req_ack_receiver_if.sv
// Bundle of the req/ack handshake, the downstream valid/ready stream and status.
// The slave modport is the receiver; the master modport is the sender plus the downstream sink.
interface hs_req_ack_receiver_if
    import hs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int FILL_W = fill_width(DEPTH);

    // req_i/ack_o form a 4-phase level handshake; data_i is held while req_i=1 until ack_o=1.
    // m_valid_o/m_ready_i: a word transfers on any cycle both are high; m_data_o is stable while
    // m_valid_o=1 and m_ready_i=0, and m_valid_o never drops without a transfer except on reset.
    logic              req_i;
    logic [DATA_W-1:0] data_i;
    logic              ack_o;
    logic              m_valid_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_ready_i;
    logic [FILL_W-1:0] fill_o;
    logic              busy_o;
    rx_state_e         state_o;

    modport slave (
        input  req_i, data_i, m_ready_i,
        output ack_o, m_valid_o, m_data_o, fill_o, busy_o, state_o
    );

    modport master (
        output req_i, data_i, m_ready_i,
        input  ack_o, m_valid_o, m_data_o, fill_o, busy_o, state_o
    );

endinterface

// File: rtl/hs_sync_fifo.sv
// Single-clock circular FIFO with extra-MSB pointers and a combinational head read.
// Storage clears on reset so the head reads zero until the first write.
module hs_sync_fifo
    import hs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  logic [DATA_W-1:0]           i_push_data,
    input  logic                        i_pop,
    output logic [DATA_W-1:0]           o_pop_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [fill_width(DEPTH)-1:0] o_fill
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);

    // Full is judged on current occupancy, so a same-cycle pop never frees room for a push.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];
    assign o_fill     = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hs_req_ack_receiver.sv
// Slow-domain responder of the 4-phase req/ack handshake: synchronizes req, captures the
// held data into a FIFO, returns a registered ack and streams words out on valid/ready.
module hs_req_ack_receiver
    import hs_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   slow_clk,
    input  logic                   rst,
    hs_req_ack_receiver_if.slave   bus
);
    logic [SYNC_STAGES-1:0] r_sync;
    rx_state_e              r_state;
    logic                   r_ack;

    logic w_req_s;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    always_ff @(posedge slow_clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.req_i};
        end
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];

    // data_i is only looked at once req_s=1, when the sender guarantees it is settled.
    assign w_push = !w_full && ((r_state == ST_RX_IDLE && w_req_s) || (r_state == ST_RX_WAIT));
    assign w_pop  = !w_empty && bus.m_ready_i;

    always_ff @(posedge slow_clk) begin
        if (rst) begin
            r_state <= ST_RX_IDLE;
            r_ack   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_RX_IDLE: begin
                    if (w_req_s) begin
                        if (!w_full) begin
                            r_ack   <= 1'b1;
                            r_state <= ST_RX_ACK;
                        end else begin
                            r_state <= ST_RX_WAIT;
                        end
                    end
                end
                ST_RX_WAIT: begin
                    // A req drop here is a sender violation; the word is still taken.
                    if (!w_full) begin
                        r_ack   <= 1'b1;
                        r_state <= ST_RX_ACK;
                    end
                end
                ST_RX_ACK: begin
                    if (!w_req_s) begin
                        r_ack   <= 1'b0;
                        r_state <= ST_RX_IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= ST_RX_IDLE;
                end
            endcase
        end
    end

    hs_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (slow_clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (bus.data_i),
        .i_pop       (w_pop),
        .o_pop_data  (bus.m_data_o),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_fill      (bus.fill_o)
    );

    assign bus.ack_o     = r_ack;
    assign bus.m_valid_o = !w_empty;
    assign bus.busy_o    = (r_state != ST_RX_IDLE);
    assign bus.state_o   = r_state;

endmodule

// File: tb/tb_hs_req_ack_receiver.sv
// Directed bench for hs_req_ack_receiver: latency, ordering, backpressure, wrap and reset.
module tb_hs_req_ack_receiver;
  import hs_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int SYNC   = 2;

  // clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hs_req_ack_receiver_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  hs_req_ack_receiver #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .slow_clk (clk),
    .rst      (rst),
    .bus      (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  bit rand_mode = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_mode) bus.m_ready_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_ack(input logic lvl, input int max, input string tag);
    int k = 0;
    while (bus.ack_o !== lvl && k < max) begin
      tick(1);
      k++;
    end
    check_val(tag, 32'(bus.ack_o), 32'(lvl));
  endtask

  task automatic transfer(input logic [DATA_W-1:0] d);
    bus.data_i = d;
    bus.req_i  = 1'b1;
    wait_ack(1'b1, 60, "xfer_ack_hi");
    if (bus.ack_o === 1'b1) exp_q.push_back(d);
    bus.req_i = 1'b0;
    wait_ack(1'b0, 20, "xfer_ack_lo");
  endtask

  // scoreboard: a pop happens on the next posedge whenever valid&ready hold at negedge
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.m_valid_o === 1'b1 && bus.m_ready_i === 1'b1) begin
      n_pops++;
      check_val("sb_pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_val("sb_data", bus.m_data_o, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0;
    rst          = 1'b1;
    bus.req_i    = 1'b0;
    bus.data_i   = '0;
    bus.m_ready_i = 1'b0;
    tick(3);
    check_val("rst_ack", 32'(bus.ack_o), 32'd0);
    check_val("rst_valid", 32'(bus.m_valid_o), 32'd0);
    check_val("rst_data", bus.m_data_o, 32'd0);
    check_val("rst_fill", 32'(bus.fill_o), 32'd0);
    check_val("rst_busy", 32'(bus.busy_o), 32'd0);
    rst = 1'b0;
    tick(1);

    // single transfer with exact latency
    bus.m_ready_i = 1'b1;
    bus.data_i    = 32'hDEADBEEF;
    bus.req_i     = 1'b1;
    tick(2);
    check_val("lat_ack_early", 32'(bus.ack_o), 32'd0);
    tick(1);
    check_val("lat_ack", 32'(bus.ack_o), 32'd1);
    check_val("lat_valid", 32'(bus.m_valid_o), 32'd1);
    check_val("lat_data", bus.m_data_o, 32'hDEADBEEF);
    check_val("lat_fill", 32'(bus.fill_o), 32'd1);
    check_val("lat_busy", 32'(bus.busy_o), 32'd1);
    exp_q.push_back(32'hDEADBEEF);
    bus.req_i = 1'b0;
    tick(2);
    check_val("drop_ack_early", 32'(bus.ack_o), 32'd1);
    tick(1);
    check_val("drop_ack", 32'(bus.ack_o), 32'd0);
    check_val("drop_fill", 32'(bus.fill_o), 32'd0);
    check_val("drop_busy", 32'(bus.busy_o), 32'd0);

    // back-to-back
    pops0 = n_pops;
    for (int i = 1; i <= 6; i++) transfer(32'(i));
    tick(3);
    check_val("b2b_pops", 32'(n_pops - pops0), 32'd6);
    check_val("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

    // backpressure: 5th request stalls in WAIT
    bus.m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) transfer(32'hA0 + 32'(i));
    check_val("bp_fill_full", 32'(bus.fill_o), 32'd4);
    bus.data_i = 32'hA4;
    bus.req_i  = 1'b1;
    tick(6);
    check_val("bp_wait_ack", 32'(bus.ack_o), 32'd0);
    check_val("bp_wait_busy", 32'(bus.busy_o), 32'd1);
    check_val("bp_wait_state", 32'(bus.state_o), 32'(ST_RX_WAIT));
    check_val("bp_wait_fill", 32'(bus.fill_o), 32'd4);
    bus.m_ready_i = 1'b1;
    tick(1);
    bus.m_ready_i = 1'b0;
    check_val("bp_no_bypass_fill", 32'(bus.fill_o), 32'd3);
    check_val("bp_no_bypass_ack", 32'(bus.ack_o), 32'd0);
    tick(1);
    check_val("bp_push_ack", 32'(bus.ack_o), 32'd1);
    check_val("bp_push_fill", 32'(bus.fill_o), 32'd4);
    exp_q.push_back(32'hA4);
    bus.req_i = 1'b0;
    wait_ack(1'b0, 20, "bp_ack_lo");
    bus.m_ready_i = 1'b1;
    tick(8);
    check_val("bp_drain_fill", 32'(bus.fill_o), 32'd0);
    check_val("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // simultaneous push and pop at fill 2
    bus.m_ready_i = 1'b0;
    transfer(32'hB0);
    transfer(32'hB1);
    bus.data_i = 32'hB2;
    bus.req_i  = 1'b1;
    tick(2);
    check_val("pp_fill_before", 32'(bus.fill_o), 32'd2);
    bus.m_ready_i = 1'b1;
    tick(1);
    bus.m_ready_i = 1'b0;
    check_val("pp_fill_same", 32'(bus.fill_o), 32'd2);
    check_val("pp_ack", 32'(bus.ack_o), 32'd1);
    exp_q.push_back(32'hB2);
    bus.req_i = 1'b0;
    wait_ack(1'b0, 20, "pp_ack_lo");
    bus.m_ready_i = 1'b1;
    tick(6);
    check_val("pp_sb_empty", 32'(exp_q.size()), 32'd0);

    // pointer wrap with random backpressure
    pops0 = n_pops;
    rand_mode = 1'b1;
    for (int i = 0; i < 3 * DEPTH + 1; i++) transfer(32'hC00 + 32'(i));
    rand_mode = 1'b0;
    bus.m_ready_i = 1'b1;
    tick(8);
    check_val("wrap_pops", 32'(n_pops - pops0), 32'(3 * DEPTH + 1));
    check_val("wrap_sb_empty", 32'(exp_q.size()), 32'd0);
    check_val("wrap_fill", 32'(bus.fill_o), 32'd0);

    // reset mid-handshake
    bus.m_ready_i = 1'b0;
    transfer(32'hD0);
    transfer(32'hD1);
    bus.data_i = 32'hD2;
    bus.req_i  = 1'b1;
    wait_ack(1'b1, 20, "mid_ack_hi");
    exp_q.push_back(32'hD2);
    check_val("mid_fill", 32'(bus.fill_o), 32'd3);
    check_val("mid_state", 32'(bus.state_o), 32'(ST_RX_ACK));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    check_val("mid_rst_ack", 32'(bus.ack_o), 32'd0);
    check_val("mid_rst_fill", 32'(bus.fill_o), 32'd0);
    check_val("mid_rst_valid", 32'(bus.m_valid_o), 32'd0);
    check_val("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    bus.data_i = 32'hE0;
    tick(2);
    check_val("mid_re_ack_early", 32'(bus.ack_o), 32'd0);
    tick(1);
    check_val("mid_re_ack", 32'(bus.ack_o), 32'd1);
    check_val("mid_re_fill", 32'(bus.fill_o), 32'd1);
    exp_q.push_back(32'hE0);
    bus.req_i = 1'b0;
    wait_ack(1'b0, 20, "mid_re_ack_lo");
    bus.m_ready_i = 1'b1;
    tick(4);
    check_val("mid_sb_empty", 32'(exp_q.size()), 32'd0);
    check_val("mid_fill_end", 32'(bus.fill_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_req_ack_receiver.md
Name: hs_req_ack_receiver

Overview:
- Receiving (responder) end of the 4-phase req/ack level handshake that the fast-domain sender drives.
- Lives entirely in the slow_clk domain.
- Synchronizes the incoming request level, captures the sender's held data bus into a small FIFO, and returns a registered acknowledge level.
- Delivers captured words downstream on a valid/ready stream with backpressure.

Parameters:
- DATA_W, 32, width of the data bus and of each FIFO entry.
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- SYNC_STAGES, 2, flops in the req_i synchronizer; ≥2.

Ports:
- slow_clk  in  1  sole clock for all logic.
- rst  in  1  synchronous, active-high reset.
- req_i  in  1  request level from the sender; asynchronous to slow_clk.
- data_i  in  DATA_W  sender data; held stable by the sender while req_i=1 until ack_o is seen high.
- ack_o  out  1  acknowledge level to the sender; driven directly from a flop.
- m_valid_o  out  1  FIFO head is valid.
- m_data_o  out  DATA_W  FIFO head data.
- m_ready_i  in  1  downstream accepts the head when m_valid_o=1.
- fill_o  out  $clog2(DEPTH+1)  current FIFO occupancy.
- busy_o  out  1  FSM is not in ST_RX_IDLE.

Behaviour:
- Reset is synchronous: on any slow_clk edge with rst=1, all flops clear.
  - Cleared state: sync chain=0, FSM=ST_RX_IDLE, ack_o=0, FIFO pointers=0.
  - Output values after reset: m_valid_o=0, m_data_o=0, fill_o=0, busy_o=0.
- Synchronizer: req_s is the last stage of SYNC_STAGES flops on req_i. data_i is never synchronized; it is sampled only when req_s=1, which the protocol guarantees is stable.
- ST_RX_IDLE (ack_o=0):
  - If req_s=1 and FIFO not full: push data_i, set ack_o<=1, go to ST_RX_ACK.
  - If req_s=1 and FIFO full: go to ST_RX_WAIT. No push, ack stays 0.
- ST_RX_WAIT (ack_o=0): when FIFO not full, push data_i, set ack_o<=1, go to ST_RX_ACK.
- ST_RX_ACK (ack_o=1): when req_s=0, set ack_o<=0 and go to ST_RX_IDLE. A new request is accepted only after returning to IDLE, so exactly one push occurs per req pulse.
- Latency: req_i rise sampled at edge 0 gives req_s=1 after edge SYNC_STAGES-1. Push and ack_o=1 are visible after the next edge, i.e. SYNC_STAGES+1 edges from the sampled rise.
- FIFO:
  - Circular buffer with pointers one bit wider than log2(DEPTH); pointers wrap naturally.
  - full = (MSBs differ and index bits equal); empty = (pointers equal).
  - Pop when m_valid_o & m_ready_i.
  - m_data_o is the head entry read combinationally; it reads 0 when empty only if storage was never written (contents are don't-care when empty).
  - Push while full is impossible; the FSM stalls in WAIT.
  - Push and pop in the same cycle are both allowed when not full: fill is unchanged.
  - full is evaluated on the current occupancy. A pop in the same cycle does not enable a push; no bypass.
  - fill_o counts 0..DEPTH inclusive.
- Reset mid-handshake: ack_o drops to 0 and the FIFO is emptied. If req_i is still high after reset, the transfer is treated as a new request (the sender is reset by the same system reset).
- req_i glitching low while in WAIT is a sender protocol violation. The FSM still pushes once space is available; no checking is done beyond that.

Decomposition:
- Shared package hs_pkg holds typedef enum logic [1:0] rx_state_e {ST_RX_IDLE, ST_RX_WAIT, ST_RX_ACK}.
- The same package is reused by the sender-side state types.
- One sub-module, hs_sync_fifo (DATA_W, DEPTH): push/pop/full/empty/fill, same clock and reset.
- Synchronizer flops stay inline in the top.

Test Plan:
- Single transfer, SYNC_STAGES=2, m_ready_i=1: raise req_i with data_i=32'hDEADBEEF → ack_o rises 3 edges later, m_valid_o=1 with m_data_o=32'hDEADBEEF. Dropping req_i → ack_o falls 3 edges later; fill_o returns to 0 after the pop.
- Back-to-back: 6 full 4-phase transfers 32'h1..32'h6 with m_ready_i=1 → exactly 6 pops, in order, no duplicates.
- Backpressure: m_ready_i=0, 5 requests with DEPTH=4 → fill_o=4 and busy_o=1. The 5th request stays in WAIT with ack_o=0. Asserting m_ready_i for 1 cycle → 5th word pushed, ack_o=1, fill_o stays 4.
- Simultaneous push/pop at fill_o=2: push and pop on the same edge → fill_o stays 2 and ordering is preserved.
- Pointer wrap: 3×DEPTH+1 transfers with random m_ready_i → scoreboard matches all words in order.
- Reset mid-operation: assert rst for 1 cycle while in ST_RX_ACK with fill_o=3 → next cycle ack_o=0, fill_o=0, m_valid_o=0, busy_o=0. With req_i still 1 after reset → one new push after SYNC_STAGES+1 edges.
